// File: rtl/evt_window_counter_pkg.sv
// evt_win_pkg: shared FSM state type and saturating-increment helper for the window counter
package evt_win_pkg;
  typedef enum logic {IDLE, RUN} evt_win_state_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max;
    max = (width >= 32) ? '1 : (32'd1 << width) - 32'd1;
    return (value >= max) ? max : value + 32'd1;
  endfunction
endpackage

// File: rtl/evt_window_counter_if.sv
// evt_window_counter_if: result handshake (count, sat flag, drop counter) between counter and consumer
interface evt_window_counter_if #(parameter int CNT_W = 8) ();
  logic [CNT_W-1:0] cnt_data;
  logic [CNT_W-1:0] drop_cnt;
  logic cnt_valid;
  logic cnt_ready;
  logic cnt_sat;
  modport master(output cnt_data, cnt_valid, cnt_sat, drop_cnt, input cnt_ready);
  modport slave(input cnt_data, cnt_valid, cnt_sat, drop_cnt, output cnt_ready);
endinterface

// File: rtl/evt_window_counter_edge_det.sv
// evt_win_edge_det: rising-edge detector with optional 2-flop synchronizer (EVT_WIN_SYNC_EN)
module evt_win_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic evt_in,
  output logic rise
);
  logic evt_s, prev;
`ifdef EVT_WIN_SYNC_EN
  logic [1:0] sync;
  // two-flop synchronizer for an event line from a foreign clock domain
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '0;
    else sync <= {sync[0], evt_in};
  assign evt_s = sync[1];
`else
  assign evt_s = evt_in;
`endif
  // previous sample; reset low so a line already high counts as one edge
  always_ff @(posedge clk or posedge rst)
    if (rst) prev <= 1'b0;
    else prev <= evt_s;
  assign rise = evt_s & ~prev;
endmodule

// File: rtl/evt_window_counter.sv
// evt_window_counter: counts event rising edges per WIN_CYC-cycle window, valid/ready result, drop counter (EVT_WIN_SYNC_EN selects input sync)
module evt_window_counter
  import evt_win_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int WIN_CYC = 16
) (
  input logic clk,
  input logic rst,
  input logic en,
  input logic evt_in,
  evt_window_counter_if.master bus
);
  localparam int TW = $clog2(WIN_CYC);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [TW-1:0] LAST = TW'(WIN_CYC - 1);
  evt_win_state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [CNT_W-1:0] acc, acc_n, data_n, drop_n;
  logic sat, sat_n, valid_n, osat_n, rise;
  evt_win_edge_det u_edge (.clk(clk), .rst(rst), .evt_in(evt_in), .rise(rise));
  // next state: idle/abort clears the partial window, window close loads or drops the result
  always_comb begin
    state_n = state;
    timer_n = timer;
    acc_n = acc;
    sat_n = sat;
    data_n = bus.cnt_data;
    osat_n = bus.cnt_sat;
    drop_n = bus.drop_cnt;
    valid_n = bus.cnt_valid & ~bus.cnt_ready;
    if (state == IDLE || !en) begin
      state_n = (state == IDLE && en) ? RUN : IDLE;
      timer_n = '0;
      acc_n = '0;
      sat_n = 1'b0;
    end else begin
      acc_n = rise ? CNT_W'(sat_inc(32'(acc), CNT_W)) : acc;
      sat_n = sat | (rise & (acc == MAX));
      timer_n = timer + 1'b1;
      if (timer == LAST) begin
        if (!bus.cnt_valid || bus.cnt_ready) begin
          data_n = acc_n;
          osat_n = sat_n;
          valid_n = 1'b1;
        end else begin
          drop_n = CNT_W'(sat_inc(32'(bus.drop_cnt), CNT_W));
        end
        timer_n = '0;
        acc_n = '0;
        sat_n = 1'b0;
      end
    end
  end
  // state, window accumulator and output register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      acc <= '0;
      sat <= 1'b0;
      bus.cnt_data <= '0;
      bus.cnt_sat <= 1'b0;
      bus.cnt_valid <= 1'b0;
      bus.drop_cnt <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      acc <= acc_n;
      sat <= sat_n;
      bus.cnt_data <= data_n;
      bus.cnt_sat <= osat_n;
      bus.cnt_valid <= valid_n;
      bus.drop_cnt <= drop_n;
    end
endmodule

// File: tb/tb_evt_window_counter.sv
// tb_evt_window_counter: directed checks of window counting, back-pressure drops, saturation, abort and reset
module tb_evt_window_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic evt = 1'b0;
  logic ready = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  evt_window_counter_if #(.CNT_W(8)) bus ();
  evt_window_counter_if #(.CNT_W(3)) bus3 ();
  assign bus.cnt_ready = ready;
  assign bus3.cnt_ready = ready;
  evt_window_counter #(.CNT_W(8), .WIN_CYC(16)) dut (
    .clk(clk), .rst(rst), .en(en), .evt_in(evt), .bus(bus)
  );
  evt_window_counter #(.CNT_W(3), .WIN_CYC(32)) dut3 (
    .clk(clk), .rst(rst), .en(en), .evt_in(evt), .bus(bus3)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic e);
    evt = e;
    @(negedge clk);
  endtask
  task automatic window(input int len, input int edges, input logic r, input logic r_last);
    for (int i = 0; i < len; i++) begin
      ready = (i == len - 1) ? r_last : r;
      tick((i < 2 * edges) && (i % 2 == 0));
    end
  endtask
  task automatic start();
    en = 1'b1;
    tick(1'b0);
  endtask
  task automatic stop();
    en = 1'b0;
    tick(1'b0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_data", 32'(bus.cnt_data), 0);
    chk("rst_valid", 32'(bus.cnt_valid), 0);
    chk("rst_sat", 32'(bus.cnt_sat), 0);
    chk("rst_drop", 32'(bus.drop_cnt), 0);
    chk("rst_valid3", 32'(bus3.cnt_valid), 0);
    rst = 1'b0;
    ready = 1'b1;
    start();
    window(16, 8, 1'b1, 1'b1);
    chk("t1_w1_data", 32'(bus.cnt_data), 8);
    chk("t1_w1_valid", 32'(bus.cnt_valid), 1);
    chk("t1_w1_sat", 32'(bus.cnt_sat), 0);
    chk("t1_w1_drop", 32'(bus.drop_cnt), 0);
    window(16, 8, 1'b1, 1'b1);
    chk("t1_w2_data", 32'(bus.cnt_data), 8);
    chk("t1_w2_valid", 32'(bus.cnt_valid), 1);
    chk("t1_w2_drop", 32'(bus.drop_cnt), 0);
    stop();
    chk("t2_stop_valid", 32'(bus.cnt_valid), 0);
    ready = 1'b0;
    start();
    window(16, 5, 1'b0, 1'b0);
    chk("t2_w1_data", 32'(bus.cnt_data), 5);
    chk("t2_w1_valid", 32'(bus.cnt_valid), 1);
    chk("t2_w1_drop", 32'(bus.drop_cnt), 0);
    window(16, 5, 1'b0, 1'b0);
    chk("t2_w2_data", 32'(bus.cnt_data), 5);
    chk("t2_w2_drop", 32'(bus.drop_cnt), 1);
    window(16, 5, 1'b0, 1'b0);
    chk("t2_w3_data", 32'(bus.cnt_data), 5);
    chk("t2_w3_valid", 32'(bus.cnt_valid), 1);
    chk("t2_w3_drop", 32'(bus.drop_cnt), 2);
    window(16, 3, 1'b1, 1'b1);
    chk("t2_w4_data", 32'(bus.cnt_data), 3);
    chk("t2_w4_valid", 32'(bus.cnt_valid), 1);
    chk("t2_w4_drop", 32'(bus.drop_cnt), 2);
    window(16, 6, 1'b0, 1'b1);
    chk("t5_data", 32'(bus.cnt_data), 6);
    chk("t5_valid", 32'(bus.cnt_valid), 1);
    chk("t5_drop", 32'(bus.drop_cnt), 2);
    ready = 1'b1;
    for (int i = 0; i < 9; i++) tick((i < 8) && (i % 2 == 0));
    stop();
    chk("t4_abort_valid", 32'(bus.cnt_valid), 0);
    chk("t4_abort_data", 32'(bus.cnt_data), 6);
    for (int i = 0; i < 4; i++) tick(i % 2 == 0);
    chk("t4_idle_valid", 32'(bus.cnt_valid), 0);
    start();
    window(16, 2, 1'b1, 1'b1);
    chk("t4_restart_data", 32'(bus.cnt_data), 2);
    chk("t4_restart_valid", 32'(bus.cnt_valid), 1);
    chk("t4_restart_drop", 32'(bus.drop_cnt), 2);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) tick(i % 2 == 0);
    chk("t6_pre_valid", 32'(bus.cnt_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_data", 32'(bus.cnt_data), 0);
    chk("t6_valid", 32'(bus.cnt_valid), 0);
    chk("t6_sat", 32'(bus.cnt_sat), 0);
    chk("t6_drop", 32'(bus.drop_cnt), 0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    start();
    window(32, 10, 1'b1, 1'b1);
    chk("t3_w1_data", 32'(bus3.cnt_data), 7);
    chk("t3_w1_sat", 32'(bus3.cnt_sat), 1);
    chk("t3_w1_valid", 32'(bus3.cnt_valid), 1);
    window(32, 2, 1'b1, 1'b1);
    chk("t3_w2_data", 32'(bus3.cnt_data), 2);
    chk("t3_w2_sat", 32'(bus3.cnt_sat), 0);
    chk("t3_w2_valid", 32'(bus3.cnt_valid), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
